// File: rtl/qspi_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : qspi_mem_arbiter
//  Purpose  : Shares one QSPI memory controller between the CPU fetch port and
//             the CPU data port. One locked transaction at a time, address
//             decode to a one-hot chip select, and a timeout on mem_ready.
//  Revision : 1.0 - initial release
// ============================================================================
module qspi_mem_arbiter #(
   parameter int AW           = 26,
   parameter int D_MAX_CONSEC = 4,
   parameter int TIMEOUT      = 255
) (
   input  logic          clk,
   input  logic          rst,
   // instruction-fetch port (read only)
   input  logic          i_valid,
   input  logic [AW-1:0] i_addr,
   output logic [31:0]   i_rdata,
   output logic          i_ready,
   output logic          i_err,
   // data port
   input  logic          d_valid,
   input  logic [AW-1:0] d_addr,
   input  logic [3:0]    d_wstrb,
   input  logic [31:0]   d_wdata,
   output logic [31:0]   d_rdata,
   output logic          d_ready,
   output logic          d_err,
   // downstream QSPI controller
   output logic          mem_valid,
   output logic [AW-3:0] mem_addr,
   output logic [2:0]    mem_ce_sel,
   output logic [3:0]    mem_wstrb,
   output logic [31:0]   mem_wdata,
   input  logic [31:0]   mem_rdata,
   input  logic          mem_ready,
   output logic          busy
);

   localparam int            SCW        = $clog2(D_MAX_CONSEC + 1);
   localparam logic [SCW-1:0] STARVE_MAX = SCW'(D_MAX_CONSEC);
   // last ISSUE cycle index; mem_valid stays high for TIMEOUT cycles in total
   localparam logic [7:0]    TMO_LAST   = 8'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_RESP  = 2'd2
   } state_t;

   state_t          r_state;
   state_t          w_state_next;
   logic            r_owner_d;     // 1: data port owns the transaction
   logic [SCW-1:0]  r_starve;      // consecutive data grants while fetch waits
   logic [7:0]      r_tmo;         // cycles spent in ISSUE

   logic            w_pick_d;
   logic [AW-1:0]   w_addr;
   logic [1:0]      w_sel;
   logic [2:0]      w_ce;
   logic            w_grant;
   logic            w_resp;
   logic            w_resp_d;
   logic            w_resp_err;
   logic [31:0]     w_resp_data;
   logic            w_tmo_hit;

   assign busy = (r_state != ST_IDLE);

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Winner selection, decode and next-state / response decisions
   always_comb begin
      w_state_next = r_state;
      w_pick_d     = d_valid && !(i_valid && (r_starve == STARVE_MAX));
      w_addr       = w_pick_d ? d_addr : i_addr;
      w_sel        = w_addr[AW-1:AW-2];
      w_ce         = 3'b000;
      w_grant      = 1'b0;
      w_resp       = 1'b0;
      w_resp_d     = r_owner_d;
      w_resp_err   = 1'b0;
      w_resp_data  = 32'hFFFF_FFFF;
      w_tmo_hit    = (r_tmo == TMO_LAST);

      case (w_sel)
         2'd0:    w_ce = 3'b001;
         2'd1:    w_ce = 3'b010;
         2'd2:    w_ce = 3'b100;
         default: w_ce = 3'b000;
      endcase

      case (r_state)
         ST_IDLE: begin
            if (i_valid || d_valid) begin
               w_grant = 1'b1;
               if (w_sel == 2'd3) begin
                  // unmapped device: answer with an error, never touch memory
                  w_state_next = ST_RESP;
                  w_resp       = 1'b1;
                  w_resp_d     = w_pick_d;
                  w_resp_err   = 1'b1;
               end else begin
                  w_state_next = ST_ISSUE;
               end
            end
         end
         ST_ISSUE: begin
            // a completion in the final allowed cycle beats the timeout
            if (mem_ready) begin
               w_state_next = ST_RESP;
               w_resp       = 1'b1;
               w_resp_data  = mem_rdata;
            end else if (w_tmo_hit) begin
               w_state_next = ST_RESP;
               w_resp       = 1'b1;
               w_resp_err   = 1'b1;
            end
         end
         ST_RESP: begin
            w_state_next = ST_IDLE;
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   // Owner latch, starvation counter and timeout counter
   always_ff @(posedge clk) begin
      if (rst) begin
         r_owner_d <= 1'b0;
         r_starve  <= '0;
         r_tmo     <= '0;
      end else begin
         if (r_state == ST_ISSUE) begin
            r_tmo <= r_tmo + 8'd1;
         end
         if (w_grant) begin
            r_owner_d <= w_pick_d;
            r_tmo     <= '0;
            if (w_pick_d && i_valid) begin
               if (r_starve != STARVE_MAX) begin
                  r_starve <= r_starve + SCW'(1);
               end
            end else begin
               r_starve <= '0;
            end
         end
      end
   end

   // Downstream request: launched on a mapped grant, held through ISSUE
   always_ff @(posedge clk) begin
      if (rst) begin
         mem_valid  <= 1'b0;
         mem_addr   <= '0;
         mem_ce_sel <= 3'b000;
         mem_wstrb  <= 4'b0000;
         mem_wdata  <= 32'h0;
      end else begin
         if (w_grant && (w_sel != 2'd3)) begin
            mem_valid  <= 1'b1;
            mem_addr   <= w_addr[AW-3:0];
            mem_ce_sel <= w_ce;
            mem_wstrb  <= w_pick_d ? d_wstrb : 4'b0000;
            mem_wdata  <= w_pick_d ? d_wdata : 32'h0;
         end
         if (w_resp) begin
            mem_valid <= 1'b0;
         end
      end
   end

   // Per-port response registers: one-cycle ready/err pulse, sticky rdata
   always_ff @(posedge clk) begin
      if (rst) begin
         i_rdata <= 32'h0;
         i_ready <= 1'b0;
         i_err   <= 1'b0;
         d_rdata <= 32'h0;
         d_ready <= 1'b0;
         d_err   <= 1'b0;
      end else begin
         i_ready <= 1'b0;
         i_err   <= 1'b0;
         d_ready <= 1'b0;
         d_err   <= 1'b0;
         if (w_resp) begin
            if (w_resp_d) begin
               d_rdata <= w_resp_data;
               d_ready <= 1'b1;
               d_err   <= w_resp_err;
            end else begin
               i_rdata <= w_resp_data;
               i_ready <= 1'b1;
               i_err   <= w_resp_err;
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_qspi_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_qspi_mem_arbiter
//  Purpose  : Directed self-checking bench for qspi_mem_arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_qspi_mem_arbiter;

   localparam int AW = 26;

   logic          clk;
   logic          rst;
   logic          i_valid;
   logic [AW-1:0] i_addr;
   logic [31:0]   i_rdata;
   logic          i_ready;
   logic          i_err;
   logic          d_valid;
   logic [AW-1:0] d_addr;
   logic [3:0]    d_wstrb;
   logic [31:0]   d_wdata;
   logic [31:0]   d_rdata;
   logic          d_ready;
   logic          d_err;
   logic          mem_valid;
   logic [AW-3:0] mem_addr;
   logic [2:0]    mem_ce_sel;
   logic [3:0]    mem_wstrb;
   logic [31:0]   mem_wdata;
   logic [31:0]   mem_rdata;
   logic          mem_ready;
   logic          busy;

   int checks = 0;
   int errors = 0;

   qspi_mem_arbiter #(
      .AW           (AW),
      .D_MAX_CONSEC (4),
      .TIMEOUT      (8)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .i_valid    (i_valid),
      .i_addr     (i_addr),
      .i_rdata    (i_rdata),
      .i_ready    (i_ready),
      .i_err      (i_err),
      .d_valid    (d_valid),
      .d_addr     (d_addr),
      .d_wstrb    (d_wstrb),
      .d_wdata    (d_wdata),
      .d_rdata    (d_rdata),
      .d_ready    (d_ready),
      .d_err      (d_err),
      .mem_valid  (mem_valid),
      .mem_addr   (mem_addr),
      .mem_ce_sel (mem_ce_sel),
      .mem_wstrb  (mem_wstrb),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata),
      .mem_ready  (mem_ready),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one clock; inputs are driven and outputs sampled 1ns after the edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Hard stop in case the sequence ever stalls
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
      $fatal(1, "watchdog expired");
   end

   initial begin
      string     order;
      logic [7:0] ord_ch;
      logic [2:0] exp_ce;
      logic [31:0] data_tag;

      rst       = 1'b1;
      i_valid   = 1'b0;
      i_addr    = '0;
      d_valid   = 1'b0;
      d_addr    = '0;
      d_wstrb   = 4'b0000;
      d_wdata   = 32'h0;
      mem_rdata = 32'h0;
      mem_ready = 1'b0;
      tick(); tick(); tick();

      // ---------------- reset state ----------------
      check("rst_busy",      busy,       0);
      check("rst_mem_valid", mem_valid,  0);
      check("rst_ce",        mem_ce_sel, 0);
      check("rst_i_ready",   i_ready,    0);
      check("rst_d_ready",   d_ready,    0);
      check("rst_i_rdata",   i_rdata,    0);
      check("rst_d_rdata",   d_rdata,    0);
      rst = 1'b0;
      tick();

      // ---------------- fetch read ----------------
      i_valid = 1'b1;
      i_addr  = 26'h0000100;
      tick();                                   // cycle 1
      check("f_mem_valid", mem_valid,  1);
      check("f_ce",        mem_ce_sel, 3'b001);
      check("f_addr",      mem_addr,   24'h000100);
      check("f_wstrb",     mem_wstrb,  4'b0000);
      check("f_busy",      busy,       1);
      mem_ready = 1'b1;
      mem_rdata = 32'hDEADBEEF;
      tick();                                   // cycle 2
      mem_ready = 1'b0;
      check("f_i_ready",   i_ready,    1);
      check("f_i_rdata",   i_rdata,    32'hDEADBEEF);
      check("f_i_err",     i_err,      0);
      check("f_d_ready",   d_ready,    0);
      check("f_mem_drop",  mem_valid,  0);
      i_valid = 1'b0;
      tick();                                   // cycle 3
      check("f_i_ready_1cyc", i_ready, 0);
      check("f_i_err_c3",     i_err,   0);
      check("f_busy_c3",      busy,    0);

      // ---------------- data write ----------------
      d_valid = 1'b1;
      d_addr  = 26'h1000040;
      d_wstrb = 4'b0011;
      d_wdata = 32'h12345678;
      tick();
      check("w_ce",    mem_ce_sel, 3'b010);
      check("w_addr",  mem_addr,   24'h000040);
      check("w_wstrb", mem_wstrb,  4'b0011);
      check("w_wdata", mem_wdata,  32'h12345678);
      tick();                                   // controller still busy: request held
      check("w_hold_valid", mem_valid,  1);
      check("w_hold_ce",    mem_ce_sel, 3'b010);
      mem_ready = 1'b1;
      mem_rdata = 32'h0;
      tick();
      mem_ready = 1'b0;
      check("w_d_ready", d_ready, 1);
      check("w_d_err",   d_err,   0);
      check("w_i_ready", i_ready, 0);
      d_valid = 1'b0;
      d_wstrb = 4'b0000;
      tick();
      check("w_d_ready_1cyc", d_ready, 0);
      check("w_i_ready_idle", i_ready, 0);
      check("w_i_rdata_keep", i_rdata, 32'hDEADBEEF);

      // ---------------- both ports continuously valid ----------------
      order   = "DDDDIDDDDI";
      i_valid = 1'b1;
      i_addr  = 26'h0000200;
      d_valid = 1'b1;
      d_addr  = 26'h1000300;
      d_wstrb = 4'b0000;
      for (int n = 0; n < 10; n++) begin
         ord_ch   = order[n];
         exp_ce   = (ord_ch == "D") ? (3'b001 << d_addr[AW-1:AW-2]) : 3'b001;
         data_tag = 32'hA000_0000 + n;
         tick();                                // grant edge
         check($sformatf("arb%0d_mem_valid", n), mem_valid, 1);
         check($sformatf("arb%0d_ce", n), mem_ce_sel, exp_ce);
         check($sformatf("arb%0d_addr", n), mem_addr,
               (ord_ch == "D") ? 32'(d_addr[AW-3:0]) : 32'(i_addr[AW-3:0]));
         mem_ready = 1'b1;
         mem_rdata = data_tag;
         tick();
         mem_ready = 1'b0;
         if (ord_ch == "D") begin
            check($sformatf("arb%0d_d_ready", n), d_ready, 1);
            check($sformatf("arb%0d_i_ready", n), i_ready, 0);
            check($sformatf("arb%0d_d_rdata", n), d_rdata, data_tag);
            // next data request alternates between devices 1 and 2
            d_addr = (d_addr[AW-1:AW-2] == 2'd1) ? (26'h2000000 | 26'(n + 16))
                                                 : (26'h1000000 | 26'(n + 16));
         end else begin
            check($sformatf("arb%0d_i_ready", n), i_ready, 1);
            check($sformatf("arb%0d_d_ready", n), d_ready, 0);
            check($sformatf("arb%0d_i_rdata", n), i_rdata, data_tag);
            i_addr = i_addr + 26'h4;
         end
         tick();                                // IDLE: next grant sampled here
      end
      i_valid = 1'b0;
      d_valid = 1'b0;
      tick();

      // ---------------- unmapped device ----------------
      d_valid = 1'b1;
      d_addr  = 26'h3000000;
      tick();
      check("u_mem_valid", mem_valid, 0);
      check("u_d_ready",   d_ready,   1);
      check("u_d_err",     d_err,     1);
      check("u_d_rdata",   d_rdata,   32'hFFFFFFFF);
      check("u_i_ready",   i_ready,   0);
      d_valid = 1'b0;
      tick();
      check("u_d_ready_1cyc", d_ready, 0);
      check("u_busy",         busy,    0);

      // mem_ready outside ISSUE must be ignored
      mem_ready = 1'b1;
      mem_rdata = 32'h55555555;
      tick();
      mem_ready = 1'b0;
      check("ign_d_ready", d_ready, 0);
      check("ign_i_ready", i_ready, 0);
      check("ign_d_rdata", d_rdata, 32'hFFFFFFFF);
      check("ign_busy",    busy,    0);

      // ---------------- timeout ----------------
      i_valid = 1'b1;
      i_addr  = 26'h0000300;
      tick();
      for (int k = 0; k < 8; k++) begin
         check($sformatf("to_mem_valid%0d", k), mem_valid, 1);
         tick();
      end
      check("to_mem_drop", mem_valid, 0);
      check("to_i_ready",  i_ready,   1);
      check("to_i_err",    i_err,     1);
      check("to_i_rdata",  i_rdata,   32'hFFFFFFFF);
      i_valid = 1'b0;
      tick();
      check("to_busy", busy, 0);

      // completion on the last allowed cycle wins over the timeout
      i_valid = 1'b1;
      i_addr  = 26'h0000304;
      tick();
      for (int k = 0; k < 7; k++) tick();
      check("tl_mem_valid8", mem_valid, 1);
      mem_ready = 1'b1;
      mem_rdata = 32'hA5A55A5A;
      tick();
      mem_ready = 1'b0;
      check("tl_i_ready", i_ready, 1);
      check("tl_i_err",   i_err,   0);
      check("tl_i_rdata", i_rdata, 32'hA5A55A5A);
      i_valid = 1'b0;
      tick();

      // ---------------- reset during ISSUE ----------------
      d_valid = 1'b1;
      d_addr  = 26'h2000010;
      tick();
      check("r_mem_valid", mem_valid, 1);
      rst     = 1'b1;
      d_valid = 1'b0;
      tick();
      check("r_mem_drop", mem_valid, 0);
      check("r_busy",     busy,      0);
      check("r_d_ready",  d_ready,   0);
      check("r_i_ready",  i_ready,   0);
      check("r_d_rdata",  d_rdata,   0);
      rst = 1'b0;
      tick();
      d_valid = 1'b1;
      d_addr  = 26'h2000020;
      tick();
      check("rr_ce",   mem_ce_sel, 3'b100);
      check("rr_addr", mem_addr,   24'h000020);
      mem_ready = 1'b1;
      mem_rdata = 32'h0BADF00D;
      tick();
      mem_ready = 1'b0;
      check("rr_d_ready", d_ready, 1);
      check("rr_d_err",   d_err,   0);
      check("rr_d_rdata", d_rdata, 32'h0BADF00D);
      d_valid = 1'b0;
      tick();
      check("rr_busy", busy, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
